// File: rtl/mips_md_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states,
// divider defaults and the divide-by-zero result constant.
package mips_md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_t;

  localparam int          DIV_CYCLES_DEF = 32;
  localparam int          CNT_W          = 6;
  localparam logic [31:0] DIVZ_LO        = 32'hFFFF_FFFF;

  function automatic logic [31:0] md_abs(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter32.sv
// Restoring unsigned 32/32 divider, one quotient bit per cycle.
// Ports: clk, reset, start/abort, dividend/divisor in; quo, rem, count, done out.
module div_iter32
  import mips_md_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      dividend,
  input  logic [31:0]      divisor,
  output logic [31:0]      quo,
  output logic [31:0]      rem,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic        busy;
  logic [31:0] dsr;
  logic [32:0] diff;

  // Trial subtract of the divisor from the shifted partial remainder.
  assign diff = {rem, quo[31]} - {1'b0, dsr};

  // High during the cycle whose closing edge performs the last iteration.
  assign done = busy && (count == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      quo   <= dividend;
      rem   <= '0;
      dsr   <= divisor;
    end else if (busy) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= {rem[30:0], quo[31]};
        quo <= {quo[30:0], 1'b0};
      end
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_hilo_unit.sv
// Multi-cycle MULT/DIV/MTHI/MTLO unit; write side of the HI/LO path.
// Ports: EX request/operands/flush in; stall, result strobe/wens/data, hi_q/lo_q out.
// Optional macro MD_DIV_ZERO_EARLY_EN: divide by zero skips the iterations.
module md_hilo_unit
  import mips_md_pkg::*;
#(
  parameter int MUL_LAT    = 2,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_md_valid,
  input  logic [2:0]  EX_md_op,
  input  logic [31:0] EX_src1,
  input  logic [31:0] EX_src2,
  input  logic        flush,
  output logic        EX_md_stall,
  output logic        md_res_valid,
  output logic        md_hi_wen,
  output logic        md_lo_wen,
  output logic [31:0] md_hi_res,
  output logic [31:0] md_lo_res,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  md_state_t        state;
  md_op_t           op, op_q;
  logic [CNT_W-1:0] cnt, div_cnt;
  logic [31:0]      a_q, b_q;
  logic [31:0]      res_hi_q, res_lo_q;
  logic             mt_hi_q, mt_lo_q;
  logic             is_mul, is_div, accept;
  logic             early_z, div_start, div_done;
  logic             done_ok;
  logic [31:0]      quo, rem;
  logic [31:0]      done_hi, done_lo;
  logic signed [63:0] sprod;
  logic [63:0]      uprod, prod;
  logic             qneg, rneg, dz;

  assign op     = md_op_t'(EX_md_op);
  assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign accept = (state == ST_IDLE) && EX_md_valid && !flush;

`ifdef MD_DIV_ZERO_EARLY_EN
  assign early_z = (EX_src2 == 32'd0);
`else
  assign early_z = 1'b0;
`endif

  assign div_start = accept && is_div && !early_z;

  div_iter32 #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .abort   (flush),
    .dividend(md_abs(EX_src1, op == MD_DIV)),
    .divisor (md_abs(EX_src2, op == MD_DIV)),
    .quo     (quo),
    .rem     (rem),
    .count   (div_cnt),
    .done    (div_done)
  );

  assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign uprod = {32'd0, a_q} * {32'd0, b_q};
  assign prod  = (op_q == MD_MULT) ? 64'(sprod) : uprod;

  // Divider works on magnitudes; signs are restored here.
  assign dz   = (b_q == 32'd0);
  assign qneg = (op_q == MD_DIV) && (a_q[31] ^ b_q[31]);
  assign rneg = (op_q == MD_DIV) && a_q[31];

  always_comb begin
    done_hi = prod[63:32];
    done_lo = prod[31:0];
    if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
      if (dz) begin
        done_hi = a_q;
        done_lo = DIVZ_LO;
      end else begin
        done_hi = rneg ? (~rem + 32'd1) : rem;
        done_lo = qneg ? (~quo + 32'd1) : quo;
      end
    end
  end

  // A flush in DONE kills the strobe, so the strobe is gated combinationally.
  assign done_ok      = (state == ST_DONE) && !flush && !reset;
  assign md_res_valid = done_ok || ((mt_hi_q || mt_lo_q) && !reset);
  assign md_hi_wen    = done_ok || (mt_hi_q && !reset);
  assign md_lo_wen    = done_ok || (mt_lo_q && !reset);
  assign md_hi_res    = (state == ST_DONE) ? done_hi : res_hi_q;
  assign md_lo_res    = (state == ST_DONE) ? done_lo : res_lo_q;

  assign EX_md_stall = !reset && (
      (accept && (is_mul || is_div)) ||
      (((state == ST_MUL) || (state == ST_DIV)) && !flush));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      mt_hi_q  <= 1'b0;
      mt_lo_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mt_hi_q <= accept && (op == MD_MTHI);
      mt_lo_q <= accept && (op == MD_MTLO);
      if (md_res_valid && md_hi_wen) hi_q <= md_hi_res;
      if (md_res_valid && md_lo_wen) lo_q <= md_lo_res;
      if (done_ok) begin
        res_hi_q <= done_hi;
        res_lo_q <= done_lo;
      end
      if (flush && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              cnt <= '0;
              if (is_mul || is_div) begin
                a_q  <= EX_src1;
                b_q  <= EX_src2;
                op_q <= op;
              end
              if (is_mul) state <= ST_MUL;
              if (is_div) state <= early_z ? ST_DONE : ST_DIV;
              if (op == MD_MTHI) res_hi_q <= EX_src1;
              if (op == MD_MTLO) res_lo_q <= EX_src1;
            end
          end
          ST_MUL: begin
            if (cnt == CNT_W'(MUL_LAT - 1)) state <= ST_DONE;
            else cnt <= cnt + 1'b1;
          end
          ST_DIV: begin
            cnt <= div_cnt;
            if (div_done) state <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed bench for md_hilo_unit with a result scoreboard.
// Drives on posedge+1, samples on negedge.
module tb_md_hilo_unit;
  import mips_md_pkg::*;

`ifdef MD_DIV_ZERO_EARLY_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam int MLAT = 3;
  localparam int DLAT = 33;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hw;
    logic        lw;
  } exp_t;

  logic        clk, reset, EX_md_valid, flush;
  logic [2:0]  EX_md_op;
  logic [31:0] EX_src1, EX_src2;
  logic        EX_md_stall, md_res_valid, md_hi_wen, md_lo_wen;
  logic [31:0] md_hi_res, md_lo_res, hi_q, lo_q;

  exp_t        sb[$];
  logic [31:0] mhi, mlo;
  int          checks = 0;
  int          errors = 0;

  md_hilo_unit #(.MUL_LAT(2), .DIV_CYCLES(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .EX_md_valid (EX_md_valid),
    .EX_md_op    (EX_md_op),
    .EX_src1     (EX_src1),
    .EX_src2     (EX_src2),
    .flush       (flush),
    .EX_md_stall (EX_md_stall),
    .md_res_valid(md_res_valid),
    .md_hi_wen   (md_hi_wen),
    .md_lo_wen   (md_lo_wen),
    .md_hi_res   (md_hi_res),
    .md_lo_res   (md_lo_res),
    .hi_q        (hi_q),
    .lo_q        (lo_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el,
                          input logic hw, input logic lw);
    exp_t e;
    if (hw) mhi = eh;
    if (lw) mlo = el;
    e.hi = mhi;
    e.lo = mlo;
    e.hw = hw;
    e.lw = lw;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (md_res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 66'(md_res_valid), 66'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {md_hi_res, md_lo_res, md_hi_wen, md_lo_wen},
            {e.hi, e.lo, e.hw, e.lw});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the strobe cycle.
  task automatic do_op(input string tag, input md_op_t op,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input int lat, input logic [31:0] eh,
                       input logic [31:0] el, input logic hw,
                       input logic lw);
    bit seen, held, md;
    seen = 0;
    held = 1;
    md   = (op != MD_MTHI) && (op != MD_MTLO);
    push_exp(eh, el, hw, lw);
    EX_md_valid = 1'b1;
    EX_md_op    = 3'(op);
    EX_src1     = s1;
    EX_src2     = s2;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (held) chk({tag, "_stall"}, 66'(EX_md_stall), 66'(md && k < lat));
      if (md_res_valid) begin
        seen = 1;
        chk({tag, "_latency"}, 66'(k), 66'(lat));
      end
      if (held && !EX_md_stall) held = 0;
      @(posedge clk);
      #1;
      if (!held) EX_md_valid = 1'b0;
    end
    EX_md_valid = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 66'(0), 66'(1));
    chk({tag, "_hi_q"}, 66'(hi_q), 66'(mhi));
    chk({tag, "_lo_q"}, 66'(lo_q), 66'(mlo));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 66'(EX_md_stall), 66'(0));
    chk({tag, "_strobe"}, {md_res_valid, md_hi_wen, md_lo_wen}, 66'(0));
    chk({tag, "_res"}, {md_hi_res, md_lo_res}, 66'(0));
    chk({tag, "_hilo"}, {hi_q, lo_q}, 66'(0));
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    EX_md_valid = 1'b0;
    EX_md_op    = '0;
    EX_src1     = '0;
    EX_src2     = '0;
    mhi         = '0;
    mlo         = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;

    do_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MLAT,
          32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 1);
    do_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MLAT,
          32'h0000_0002, 32'hFFFF_FFFA, 1, 1);
    do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, DLAT,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1);
    do_op("divu", MD_DIVU, 32'd100, 32'd7, DLAT, 32'd2, 32'd14, 1, 1);
    do_op("div_negdsr", MD_DIV, 32'd7, 32'hFFFF_FFFE, DLAT,
          32'd1, 32'hFFFF_FFFD, 1, 1);
    do_op("divu_zero", MD_DIVU, 32'h1234, 32'd0, ZLAT,
          32'h1234, 32'hFFFF_FFFF, 1, 1);
    do_op("div_zero", MD_DIV, 32'hFFFF_FFF0, 32'd0, ZLAT,
          32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 1);

    // MTHI then MTLO back to back
    push_exp(32'hDEAD_BEEF, 32'h0, 1, 0);
    EX_md_valid = 1'b1;
    EX_md_op    = 3'(MD_MTHI);
    EX_src1     = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi_stall", 66'(EX_md_stall), 66'(0));
    @(posedge clk);
    #1;
    push_exp(32'h0, 32'h0BAD_F00D, 0, 1);
    EX_md_op = 3'(MD_MTLO);
    EX_src1  = 32'h0BAD_F00D;
    @(negedge clk);
    chk("mtlo_stall", 66'(EX_md_stall), 66'(0));
    chk("mthi_strobe", 66'(md_res_valid), 66'(1));
    @(posedge clk);
    #1;
    EX_md_valid = 1'b0;
    @(negedge clk);
    chk("mtlo_strobe", 66'(md_res_valid), 66'(1));
    @(posedge clk);
    #1;
    chk("mt_hi_q", 66'(hi_q), 66'(32'hDEAD_BEEF));
    chk("mt_lo_q", 66'(lo_q), 66'(32'h0BAD_F00D));

    // DIV flushed ten cycles after accept
    EX_md_valid = 1'b1;
    EX_md_op    = 3'(MD_DIV);
    EX_src1     = 32'd1000;
    EX_src2     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush       = 1'b1;
    EX_md_valid = 1'b0;
    @(negedge clk);
    chk("flush_stall", 66'(EX_md_stall), 66'(0));
    chk("flush_strobe", 66'(md_res_valid), 66'(0));
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("flush_idle", 66'(EX_md_stall), 66'(0));
    chk("flush_hilo", {hi_q, lo_q}, {2'b0, mhi, mlo});
    do_op("mult_post", MD_MULT, 32'd5, 32'd6, MLAT, 32'd0, 32'd30, 1, 1);

    // reset in the middle of a DIV
    EX_md_valid = 1'b1;
    EX_md_op    = 3'(MD_DIV);
    EX_src1     = 32'd77;
    EX_src2     = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    reset       = 1'b1;
    EX_md_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    chk_zero("midreset");
    repeat (40) @(posedge clk);
    #1;
    chk("midreset_quiet", {hi_q, lo_q}, 66'(0));
    do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DLAT,
          32'h0, 32'h8000_0000, 1, 1);

    repeat (3) @(posedge clk);
    chk("sb_drained", 66'(sb.size()), 66'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_hilo_unit.md
Name: md_hilo_unit

Overview:
- Multi-cycle multiply/divide unit in EX. Produces the HI/LO results that the HI/LO forwarding logic consumes: it is the write side of the HI/LO path.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and stalls the front of the pipeline while busy.
- Emits a one-cycle result strobe with HI/LO data and per-register write enables. These feed the ME-stage HI/LO write-enable/data inputs.
- Holds the architectural HI/LO registers, committed on that strobe.

Parameters:
- MUL_LAT, 2, multiply latency in cycles from accept to result strobe (>=1).
- DIV_CYCLES, 32, iterations of the radix-2 restoring divider (fixed 32 for 32-bit).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- EX_md_valid  in  1  EX holds a valid md-class instruction.
- EX_md_op  in  3  op code (package enum: MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- EX_src1  in  32  rs value (already forwarded).
- EX_src2  in  32  rt value (already forwarded).
- flush  in  1  exception/eret flush; aborts any operation.
- EX_md_stall  out  1  hold IF/ID/EX this cycle.
- md_res_valid  out  1  one-cycle result strobe.
- md_hi_wen  out  1  HI written by this result.
- md_lo_wen  out  1  LO written by this result.
- md_hi_res  out  32  new HI.
- md_lo_res  out  32  new LO.
- hi_q  out  32  architectural HI.
- lo_q  out  32  architectural LO.

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0: stall, strobe, wens, hi_q, lo_q, md_hi_res, md_lo_res.
- Accept condition: IDLE & EX_md_valid & ~flush. Operands latched on the accept edge.
- States:
  - IDLE→MUL: accept with MULT/MULTU.
  - IDLE→DIV: accept with DIV/DIVU.
  - MTHI/MTLO: no state change.
  - MUL→DONE: after MUL_LAT-1 further cycles.
  - DIV→DONE: after DIV_CYCLES iterations.
  - DONE→IDLE: unconditional.
- Stall: EX_md_stall is combinational. It is 1 in the accept cycle of MULT/DIV and in every MUL/DIV cycle, and 0 in DONE, so EX advances exactly in the DONE cycle.
- Strobe: md_res_valid=1 only in DONE, with both wens=1. Total latency: MULT = MUL_LAT+1 cycles, DIV = DIV_CYCLES+1 cycles, counted from accept to strobe.
- MTHI/MTLO:
  - Single cycle, no stall.
  - Strobe registered at the next edge: md_hi_res=src1 with hi_wen only (MTHI), or md_lo_res=src1 with lo_wen only (MTLO).
  - The other wen is 0 and the other data output holds its previous value.
- Multiply: 64-bit product, HI=[63:32], LO=[31:0]. MULT is signed, MULTU unsigned.
- Divide, signed (DIV):
  - Operate on magnitudes. Quotient sign = sign1^sign2; remainder sign = sign of dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero (both variants): LO=0xFFFFFFFF, HI=dividend. Full latency unless the optional feature is enabled.
- Commit: hi_q/lo_q update on the edge after a strobe, per wen.
- flush in any non-IDLE state: next state IDLE, no strobe, stall dropped the same cycle, hi_q/lo_q unchanged. A flush in the DONE cycle suppresses the strobe.
- reset mid-operation: same as the reset values above; the in-flight result is lost.
- EX_md_valid while busy is ignored. EX is stalled, so the same instruction is still presented and is not re-accepted.

Optional Feature:
- Macro MD_DIV_ZERO_EARLY_EN.
- Defined: divide by zero goes IDLE→DONE directly. Result strobe 1 cycle after accept; stall only in the accept cycle.
- Undefined: divide by zero runs the full DIV_CYCLES. Result values are identical in both cases.

Decomposition:
- Package mips_md_pkg: md_op enum (3 bits), md_state enum (IDLE/MUL/DIV/DONE), DIV_CYCLES default, divide-by-zero result constants.
- Sub-module div_iter32: restoring unsigned 32/32 divider with start, iteration count and done outputs. Sign handling stays in md_hilo_unit.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003, MUL_LAT=2 → stall for 3 cycles, strobe at accept+3, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9(-7) / 2 → strobe at accept+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234; latency 33 cycles, or 1 with MD_DIV_ZERO_EARLY_EN.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D back-to-back → no stall; strobes on consecutive cycles with only the matching wen set; hi_q/lo_q updated accordingly.
- DIV started, flush at accept+10 → stall drops that cycle, no strobe, hi_q/lo_q unchanged; a following MULT is accepted normally.
- Reset asserted mid-DIV → all outputs 0 the next cycle, state IDLE; DIV 0x80000000/-1 afterwards → LO=0x80000000, HI=0.
